// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    IO_ACC  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_IO  = 1'b1
  } grant_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              io_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output io_rdata, io_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  io_rdata, io_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Access-phase cycle counter; cnt==0 is the issue cycle, done marks the data cycle.
module mem_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CNT_W'(MEM_LAT));
  assign cnt_o  = cnt_q;

  // Saturate at done so MEM_LAT_MAX never wraps the 3-bit count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (inc_i && !done_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared fixed-latency memory port (CPU vs I/O).
// Define MEM_ARB_IO_EN to enable the I/O requester; otherwise only the CPU is served.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);
  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done;
  logic [CNT_W-1:0]  cnt;
  logic              done;
  logic              issue;

`ifdef MEM_ARB_IO_EN
  grant_e            last_q, last_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic              io_done;
`endif

  mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == IDLE),
    .inc_i  (state_q != IDLE),
    .cnt_o  (cnt),
    .done_o (done)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done    = 1'b0;
`ifdef MEM_ARB_IO_EN
    last_d      = last_q;
    io_rdata_d  = io_rdata_q;
    io_done     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_IO_EN
        // On a tie the requester that did not win last time goes first.
        if (bus.cpu_req && (!bus.io_req || last_q == GRANT_IO)) begin
          state_d = CPU_ACC;
          last_d  = GRANT_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
        end else if (bus.io_req) begin
          state_d = IO_ACC;
          last_d  = GRANT_IO;
          we_d    = bus.io_we;
          addr_d  = bus.io_addr;
          wdata_d = bus.io_wdata;
        end
`else
        if (bus.cpu_req) begin
          state_d = CPU_ACC;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
        end
`endif
      end
      CPU_ACC: begin
        if (done) begin
          state_d  = IDLE;
          cpu_done = 1'b1;
          if (!we_q) cpu_rdata_d = bus.mem_rdata;
        end
      end
`ifdef MEM_ARB_IO_EN
      IO_ACC: begin
        if (done) begin
          state_d = IDLE;
          io_done = 1'b1;
          if (!we_q) io_rdata_d = bus.mem_rdata;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
`ifdef MEM_ARB_IO_EN
      last_q      <= GRANT_IO;
      io_rdata_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef MEM_ARB_IO_EN
      last_q      <= last_d;
      io_rdata_q  <= io_rdata_d;
`endif
    end
  end

  // Memory strobes only in the issue cycle; address/data bus parked at 0 otherwise.
  assign issue         = (state_q != IDLE) && (cnt == '0);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & we_q;
  assign bus.mem_addr  = issue ? addr_q  : '0;
  assign bus.mem_wdata = issue ? wdata_q : '0;

  // rdata_d equals mem_rdata in the ack cycle of a read, giving the bypass.
  assign bus.cpu_ack   = cpu_done;
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done;

`ifdef MEM_ARB_IO_EN
  assign bus.io_ack    = io_done;
  assign bus.io_rdata  = io_rdata_d;
`else
  logic unused_io;
  assign unused_io     = ^{bus.io_req, bus.io_we, bus.io_addr, bus.io_wdata};
  assign bus.io_ack    = 1'b0;
  assign bus.io_rdata  = '0;
`endif
endmodule
